// File: rtl/flash_prog_phy.sv
// Responder-side flash bank model: one-word program with fixed latency and
// clear-only semantics, sequential bulk erase, and a registered read-back port.
module flash_prog_phy #(
    parameter int AddrW      = 10,
    parameter int DataW      = 32,
    parameter int ProgCycles = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flash_req_i,
    input  logic [AddrW-1:0] flash_addr_i,
    input  logic             flash_ovfl_i,
    input  logic [DataW-1:0] flash_data_i,
    output logic             flash_done_o,
    output logic             flash_error_o,
    input  logic             erase_req_i,
    output logic             erase_busy_o,
    input  logic [AddrW-1:0] rd_addr_i,
    output logic [DataW-1:0] rd_data_o
);

    localparam int         Depth   = 1 << AddrW;
    localparam logic [7:0] CntLoad = 8'(ProgCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        PROG,
        ERASE
    } state_t;

    state_t           state;
    logic [7:0]       cnt;
    logic [AddrW-1:0] addr_q;
    logic [AddrW-1:0] ptr;
    logic [DataW-1:0] data_q;
    logic             err_q;
    logic             prog_fire;
    logic             new_err;
    logic [DataW-1:0] mem [Depth];

    // Done is decoded so it lands in the same cycle the counter reaches zero.
    assign prog_fire     = (state == PROG) && flash_req_i && (cnt == '0);
    assign flash_done_o  = prog_fire;
    assign flash_error_o = prog_fire && err_q;
    assign erase_busy_o  = (state == ERASE);

    // Any bit that would go 0->1 is illegal in a clear-only array.
    assign new_err = flash_ovfl_i | (|(flash_data_i & ~mem[flash_addr_i]));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr    <= '0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (erase_req_i) begin
                        state <= ERASE;
                        ptr   <= '0;
                    end else if (flash_req_i) begin
                        addr_q <= flash_addr_i;
                        data_q <= flash_data_i;
                        err_q  <= new_err;
                        cnt    <= CntLoad;
                        state  <= PROG;
                    end
                end
                PROG: begin
                    if (!flash_req_i) begin
                        state <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ERASE: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == '1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array contents survive reset; writes are only blocked during the reset cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state == ERASE) begin
                mem[ptr] <= '1;
            end else if (prog_fire && !err_q) begin
                mem[addr_q] <= mem[addr_q] & data_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
        end else begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: tb/tb_flash_prog_phy.sv
// Self-checking bench for flash_prog_phy: directed vector table, multi-cycle
// corner sequences, and randomized programs checked against a word-array model.
module tb_flash_prog_phy;

    localparam int PC = 4;

    logic        clk;
    logic        rst;
    logic        flash_req;
    logic [9:0]  flash_addr;
    logic        flash_ovfl;
    logic [31:0] flash_data;
    logic        done;
    logic        error;
    logic        erase_req;
    logic        busy;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [1024];

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        logic        ovfl;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    flash_prog_phy #(
        .AddrW      (10),
        .DataW      (32),
        .ProgCycles (PC)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flash_req_i   (flash_req),
        .flash_addr_i  (flash_addr),
        .flash_ovfl_i  (flash_ovfl),
        .flash_data_i  (flash_data),
        .flash_done_o  (done),
        .flash_error_o (error),
        .erase_req_i   (erase_req),
        .erase_busy_o  (busy),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_prog(input logic [9:0] a, input logic [31:0] d, input logic o,
                           output logic got_err, output int lat);
        cyc();
        flash_req  = 1'b1;
        flash_addr = a;
        flash_data = d;
        flash_ovfl = o;
        #1;
        lat     = -1;
        got_err = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                cyc();
                #1;
            end
            if (done) begin
                lat     = i;
                got_err = error;
                break;
            end
        end
        cyc();
        flash_req  = 1'b0;
        flash_ovfl = 1'b0;
        #1;
    endtask

    task automatic rdchk(input string name, input logic [9:0] a, input logic [31:0] exp);
        cyc();
        rd_addr = a;
        #1;
        cyc();
        #1;
        check(name, rd_data, exp);
    endtask

    task automatic do_erase(output int n, output logic saw_done);
        cyc();
        erase_req = 1'b1;
        #1;
        n        = 0;
        saw_done = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            cyc();
            erase_req = 1'b0;
            #1;
            if (done) saw_done = 1'b1;
            if (busy) n++;
            else break;
        end
        for (int k = 0; k < 1024; k++) model_mem[k] = '1;
    endtask

    initial begin
        logic        e;
        logic        saw;
        logic        exp_err;
        logic [9:0]  a;
        logic [31:0] d;
        logic        o;
        int          lat;
        int          n;
        int          t_done [3];
        logic [9:0]  b2b_addr [3];
        logic [31:0] b2b_data [3];

        vecs[0] = '{10'h010, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678};
        vecs[1] = '{10'h010, 32'hFFFF_0000, 1'b0, 1'b1, 32'h1234_5678};
        vecs[2] = '{10'h000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[3] = '{10'h010, 32'h1234_0000, 1'b0, 1'b0, 32'h1234_0000};
        vecs[4] = '{10'h3FF, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'hA5A5_A5A5};
        vecs[5] = '{10'h3FF, 32'hA5A5_A5A4, 1'b0, 1'b0, 32'hA5A5_A5A4};
        vecs[6] = '{10'h3FF, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'hA5A5_A5A4};

        rst        = 1'b1;
        flash_req  = 1'b0;
        flash_addr = '0;
        flash_ovfl = 1'b0;
        flash_data = '0;
        erase_req  = 1'b0;
        rd_addr    = '0;
        repeat (3) cyc();
        #1;
        check("reset_done", 32'(done), 0);
        check("reset_error", 32'(error), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_rd_data", rd_data, 0);
        cyc();
        rst = 1'b0;

        do_erase(n, saw);
        check("erase_cycles", n, 1024);
        check("erase_no_done", 32'(saw), 0);
        rdchk("erase_rd_000", 10'h000, 32'hFFFF_FFFF);
        rdchk("erase_rd_3ff", 10'h3FF, 32'hFFFF_FFFF);

        for (int v = 0; v < 7; v++) begin
            do_prog(vecs[v].addr, vecs[v].data, vecs[v].ovfl, e, lat);
            check($sformatf("vec%0d_latency", v), lat, PC);
            check($sformatf("vec%0d_error", v), 32'(e), 32'(vecs[v].exp_err));
            if (!vecs[v].exp_err) model_mem[vecs[v].addr] &= vecs[v].data;
            rdchk($sformatf("vec%0d_readback", v), vecs[v].addr, vecs[v].exp_rd);
        end

        // Back-to-back: request stays high, next word presented right after each done.
        b2b_addr = '{10'h3FE, 10'h3FF, 10'h000};
        b2b_data = '{32'h0F0F_0F0F, 32'hA5A5_A5A0, 32'h00FF_00FF};
        cyc();
        flash_req  = 1'b1;
        flash_addr = b2b_addr[0];
        flash_data = b2b_data[0];
        #1;
        t_done = '{-1, -1, -1};
        saw    = 1'b0;
        begin
            int w = 0;
            for (int c = 0; c < 40 && w < 3; c++) begin
                if (c > 0) begin
                    cyc();
                    if (w > 0 && t_done[w-1] == c - 1) begin
                        flash_addr = b2b_addr[w];
                        flash_data = b2b_data[w];
                    end
                    #1;
                end
                if (done) begin
                    t_done[w] = c;
                    if (error) saw = 1'b1;
                    w++;
                end
            end
        end
        cyc();
        flash_req = 1'b0;
        #1;
        check("b2b_first_latency", t_done[0], PC);
        check("b2b_gap_1", t_done[1] - t_done[0], PC + 1);
        check("b2b_gap_2", t_done[2] - t_done[1], PC + 1);
        check("b2b_no_error", 32'(saw), 0);
        for (int k = 0; k < 3; k++) model_mem[b2b_addr[k]] &= b2b_data[k];
        rdchk("b2b_rd_3fe", 10'h3FE, 32'h0F0F_0F0F);
        rdchk("b2b_rd_3ff", 10'h3FF, 32'hA5A5_A5A0);
        rdchk("b2b_rd_000", 10'h000, 32'h00FF_00FF);

        // Abort: request dropped in the second PROG cycle.
        cyc();
        flash_req  = 1'b1;
        flash_addr = 10'h020;
        flash_data = 32'h0000_0000;
        #1;
        saw = done;
        cyc();
        #1;
        saw |= done;
        cyc();
        flash_req = 1'b0;
        #1;
        saw |= done;
        repeat (8) begin
            cyc();
            #1;
            saw |= done;
        end
        check("abort_no_done", 32'(saw), 0);
        rdchk("abort_rd_020", 10'h020, model_mem[10'h020]);

        // Erase and program requested in the same cycle: erase first.
        cyc();
        erase_req  = 1'b1;
        flash_req  = 1'b1;
        flash_addr = 10'h010;
        flash_data = 32'h0000_0000;
        #1;
        saw = done;
        n   = 0;
        for (int i = 0; i < 1100; i++) begin
            cyc();
            erase_req = 1'b0;
            #1;
            if (done) saw = 1'b1;
            if (busy) n++;
            else break;
        end
        check("race_erase_cycles", n, 1024);
        check("race_no_done_in_erase", 32'(saw), 0);
        lat = -1;
        e   = 1'b0;
        for (int j = 0; j <= 20; j++) begin
            if (j > 0) begin
                cyc();
                #1;
            end
            if (done) begin
                lat = j;
                e   = error;
                break;
            end
        end
        cyc();
        flash_req = 1'b0;
        #1;
        for (int k = 0; k < 1024; k++) model_mem[k] = '1;
        model_mem[10'h010] = '0;
        check("race_prog_latency", lat, PC);
        check("race_prog_error", 32'(e), 0);
        rdchk("race_rd_010", 10'h010, 32'h0000_0000);
        rdchk("race_rd_3fe", 10'h3FE, 32'hFFFF_FFFF);

        // Reset in the middle of a program.
        cyc();
        flash_req  = 1'b1;
        flash_addr = 10'h030;
        flash_data = 32'h0000_0000;
        #1;
        saw = done;
        cyc();
        #1;
        saw |= done;
        cyc();
        rst = 1'b1;
        #1;
        saw |= done;
        cyc();
        #1;
        check("rst_mid_rd_data", rd_data, 0);
        rst       = 1'b0;
        flash_req = 1'b0;
        #1;
        saw |= done;
        repeat (8) begin
            cyc();
            #1;
            saw |= done;
        end
        check("rst_mid_no_done", 32'(saw), 0);
        check("rst_mid_busy", 32'(busy), 0);
        rdchk("rst_mid_rd_030", 10'h030, 32'hFFFF_FFFF);

        // Randomized programs against the word-array model.
        for (int t = 0; t < 40; t++) begin
            a = 10'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 10'h3F8 : 10'h000);
            if ($urandom_range(0, 3) == 0) d = $urandom;
            else d = model_mem[a] & $urandom;
            o       = ($urandom_range(0, 7) == 0);
            exp_err = o | (|(d & ~model_mem[a]));
            do_prog(a, d, o, e, lat);
            check($sformatf("rand%0d_latency", t), lat, PC);
            check($sformatf("rand%0d_error", t), 32'(e), 32'(exp_err));
            if (!exp_err) model_mem[a] = model_mem[a] & d;
            rdchk($sformatf("rand%0d_readback", t), a, model_mem[a]);
            repeat ($urandom_range(0, 2)) cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
